// File: rtl/secded16_pkg.sv
// Shared SECDED(16,11) definitions: sizes, data position map
// and helper functions used by both encoder and decoder.
package secded16_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 16;
  localparam int SYN_W  = 4;

  // Hamming position of data bit d0..d10
  localparam int DPOS [DATA_W] = '{
    3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15
  };

  function automatic logic [DATA_W-1:0] extract_data(
    input logic [CODE_W-1:0] code
  );
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = code[DPOS[i]];
    end
    return d;
  endfunction

  function automatic logic [SYN_W-1:0] calc_syndrome(
    input logic [CODE_W-1:0] code
  );
    logic [SYN_W-1:0] syn;
    syn = '0;
    for (int p = 1; p < CODE_W; p++) begin
      for (int k = 0; k < SYN_W; k++) begin
        if (((p >> k) & 1) != 0) begin
          syn[k] = syn[k] ^ code[p];
        end
      end
    end
    return syn;
  endfunction

endpackage

// File: rtl/secded16_syndrome.sv
// Combinational SECDED decode: syndrome, overall parity,
// single-bit correction and data extraction.
module secded16_syndrome
  import secded16_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sec,
  output logic              o_ded
);

  logic [SYN_W-1:0]  w_syn;
  logic              w_par;
  logic [CODE_W-1:0] w_mask;
  logic [CODE_W-1:0] w_fix;

  assign w_syn = calc_syndrome(i_code);
  assign w_par = ^i_code;

  // Flip the bit the syndrome points at; syn=0 hits pos0, which
  // carries no data, so the overall-parity case needs no guard.
  always_comb begin
    w_mask = '0;
    if (w_par) begin
      w_mask = CODE_W'(1) << w_syn;
    end
    w_fix  = i_code ^ w_mask;
    o_data = extract_data(w_fix);
    o_sec  = w_par;
    o_ded  = !w_par && (w_syn != '0);
  end

endmodule

// File: rtl/dec_secded_16.sv
// SECDED(16,11) decoder: two-stage valid/ready pipeline with
// saturating single/double error event counters.
module dec_secded_16
  import secded16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count
);

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_sec;
  logic              r_s2_ded;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [DATA_W-1:0] w_dec_data;
  logic              w_dec_sec;
  logic              w_dec_ded;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = r_s1_valid && w_s2_adv;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_s2_valid && out_ready;

  secded16_syndrome u_syn (
    .i_code (r_s1_code),
    .o_data (w_dec_data),
    .o_sec  (w_dec_sec),
    .o_ded  (w_dec_ded)
  );

  // Stage 1: capture the raw codeword
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (w_in_hs) begin
        r_s1_code <= in_code;
      end
    end
  end

  // Stage 2: register decoded result, hold while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sec   <= 1'b0;
      r_s2_ded   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_s2_data <= w_dec_data;
        r_s2_sec  <= w_dec_sec;
        r_s2_ded  <= w_dec_ded;
      end
    end
  end

  // Saturating event counters, clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_s2_sec && (r_sec_cnt != {CNT_W{1'b1}})) begin
        r_sec_cnt <= r_sec_cnt + CNT_W'(1);
      end
      if (r_s2_ded && (r_ded_cnt != {CNT_W{1'b1}})) begin
        r_ded_cnt <= r_ded_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_sec   = r_s2_sec;
  assign out_ded   = r_s2_ded;
  assign sec_count = r_sec_cnt;
  assign ded_count = r_ded_cnt;

endmodule

// File: tb/tb_dec_secded_16.sv
// Scoreboard bench for dec_secded_16 with directed codewords.
// Expected {data,sec,ded} are hand-derived per vector.
module tb_dec_secded_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic        cnt_clr;
  logic [1:0]  sec_count;
  logic [1:0]  ded_count;

  int checks = 0;
  int errors = 0;

  logic [12:0] q [$];

  logic        m_stall;
  logic [12:0] m_held;

  always #5 clk = ~clk;

  dec_secded_16 #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sec   (out_sec),
    .out_ded   (out_ded),
    .cnt_clr   (cnt_clr),
    .sec_count (sec_count),
    .ded_count (ded_count)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop on output handshake, check hold during stall
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_stall = 1'b0;
    end else begin
      if (m_stall && out_valid) begin
        chk("hold", {out_data, out_sec, out_ded}, m_held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got %0h exp none",
                   {out_data, out_sec, out_ded});
        end else begin
          chk("out", {out_data, out_sec, out_ded}, q.pop_front());
        end
      end
      m_stall = out_valid && !out_ready;
      m_held  = {out_data, out_sec, out_ded};
    end
  end

  task automatic send(input logic [15:0] c,
                      input logic [12:0] e);
    int n;
    in_valid = 1'b1;
    in_code  = c;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0) break;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
    #3;
  endtask

  localparam logic [12:0] E_001   = {11'h001, 1'b0, 1'b0};
  localparam logic [12:0] E_001S  = {11'h001, 1'b1, 1'b0};
  localparam logic [12:0] E_013D  = {11'h013, 1'b0, 1'b1};
  localparam logic [12:0] E_002   = {11'h002, 1'b0, 1'b0};
  localparam logic [12:0] E_400   = {11'h400, 1'b0, 1'b0};

  initial begin
    m_stall   = 1'b0;
    m_held    = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_sec_cnt", 32'(sec_count), 0);
    chk("rst_ded_cnt", 32'(ded_count), 0);
    @(negedge clk);

    // 1: clean word, latency 2
    send(16'h000F, E_001);
    #1;
    chk("lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("lat2_valid", 32'(out_valid), 1);
    drain();
    chk("t1_sec_cnt", 32'(sec_count), 0);
    chk("t1_ded_cnt", 32'(ded_count), 0);

    // 2: single error at pos9
    send(16'h020F, E_001S);
    drain();
    chk("t2_sec_cnt", 32'(sec_count), 1);

    // 3: overall parity bit error
    send(16'h000E, E_001S);
    drain();
    chk("t3_sec_cnt", 32'(sec_count), 2);
    chk("t3_ded_cnt", 32'(ded_count), 0);

    // 4: double error pos5+pos9
    send(16'h022F, E_013D);
    drain();
    chk("t4_ded_cnt", 32'(ded_count), 1);
    chk("t4_sec_cnt", 32'(sec_count), 2);

    // 5: backpressure
    @(negedge clk);
    out_ready = 1'b0;
    send(16'h0033, E_002);
    send(16'h8117, E_400);
    in_valid = 1'b1;
    in_code  = 16'h020F;
    #1;
    chk("bp_in_ready", 32'(in_ready), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_valid", 32'(out_valid), 1);
    chk("bp_in_ready2", 32'(in_ready), 0);
    out_ready = 1'b1;
    send(16'h020F, E_001S);
    send(16'h000F, E_001);
    drain();

    // 6: saturation with CNT_W=2
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("clr_sec", 32'(sec_count), 0);
    chk("clr_ded", 32'(ded_count), 0);
    for (int i = 0; i < 5; i++) begin
      send(16'h020F, E_001S);
    end
    drain();
    chk("sat_sec", 32'(sec_count), 3);

    // clear in the same cycle as a sec handshake
    @(negedge clk);
    send(16'h000E, E_001S);
    @(negedge clk);
    cnt_clr = 1'b1;
    #1;
    chk("clr_pre_valid", 32'(out_valid), 1);
    @(negedge clk);
    cnt_clr = 1'b0;
    #3;
    chk("clr_hs_sec", 32'(sec_count), 0);

    // reset mid-stream
    send(16'h020F, E_001S);
    send(16'h020F, E_001S);
    @(negedge clk);
    #3;
    chk("pre_rst_sec", 32'(sec_count), 1);
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_sec", 32'(sec_count), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("post_rst_valid", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_secded_16.md
Name: dec_secded_16

Overview:
- Decoder stage downstream of the 16-bit parity encoder. Accepts 16-bit extended-Hamming SECDED codewords (11 data bits, 5 parity bits) over a valid/ready handshake.
- Corrects single-bit errors, flags double-bit errors and returns the 11-bit data word.
- Two-stage registered pipeline, full throughput of one word per cycle.
- Keeps saturating single-error and double-error event counters for status/CSR readout.

Parameters:
CNT_W, 16, width of each saturating error counter (valid range 1..32)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  codeword valid
in_ready  out  1  block can accept a codeword this cycle
in_code  in  16  received codeword; bit i = Hamming position i
out_valid  out  1  decoded word valid
out_ready  in  1  consumer accepts the word
out_data  out  11  decoded (corrected) data
out_sec  out  1  single error detected and corrected; qualified by out_valid
out_ded  out  1  double error detected, data uncorrected; qualified by out_valid
cnt_clr  in  1  synchronous clear of both counters
sec_count  out  CNT_W  count of accepted words with out_sec=1
ded_count  out  CNT_W  count of accepted words with out_ded=1

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_sec=0, out_ded=0, sec_count=0, ded_count=0. Both stage valids clear, so in_ready=1 in the first cycle after reset.
- Codeword layout:
  - pos0 = overall parity.
  - pos1, 2, 4, 8 = Hamming parity p1, p2, p4, p8.
  - Data d0..d10 at pos 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in that order.
  - Even parity throughout.
- Stage 1 (S1): registers in_code when in_valid && in_ready.
- Stage 2 (S2): registers from S1 the decoded data, sec and ded. Outputs come directly from S2 registers.
- Decode logic (between S1 and S2):
  - syn[k] = XOR of code bits whose position index has bit k set (k = 0..3).
  - P = XOR of all 16 bits.
- Decode cases:
  - syn=0, P=0: clean. Data as received, sec=0, ded=0.
  - P=1, syn=0: error in pos0. Data as received, sec=1.
  - P=1, syn!=0: invert bit syn, then extract data, sec=1.
  - P=0, syn!=0: ded=1, sec=0. Data extracted uncorrected.
- Flow control:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no bubble)
- Latency: 2 cycles from input handshake to out_valid with no backpressure.
- Backpressure:
  - While out_valid && !out_ready, S2 holds out_data/out_sec/out_ded stable.
  - S1 holds one more word, then in_ready drops.
  - No word is dropped or duplicated.
- Counters:
  - Update only on the output handshake (out_valid && out_ready): +1 to sec_count if out_sec, +1 to ded_count if out_ded.
  - Each saturates at all-ones; no wrap.
  - cnt_clr has priority over a same-cycle increment: result is 0.
- Reset mid-operation: in-flight words are discarded; counters are zeroed.
- in_code is ignored when in_valid=0 or in_ready=0.

Decomposition:
- Shared package secded16_pkg:
  - Constants DATA_W=11, CODE_W=16, SYN_W=4.
  - Data-position lookup table.
  - Function extract_data(code).
  - Function calc_syndrome(code).
  - The encoder re-uses the same position table.
- One natural sub-module: secded16_syndrome (combinational syndrome + overall parity + correction). Pipeline/handshake and counters stay in the top.

Test Plan:
1. Clean word: in_code=16'h000F (data 11'h001), out_ready=1 -> 2 cycles later out_valid=1, out_data=11'h001, sec=0, ded=0; counters unchanged.
2. Single error: in_code=16'h020F (pos9 flipped) -> out_data=11'h001, out_sec=1; sec_count 0->1 on handshake.
3. Overall-parity error: in_code=16'h000E -> out_data=11'h001, out_sec=1, out_ded=0.
4. Double error: in_code=16'h022F (pos5 and pos9 flipped) -> out_ded=1, out_sec=0, out_data=11'h013; ded_count increments.
5. Backpressure:
   - Stream 4 words back-to-back with out_ready=0 for 3 cycles.
   - in_ready drops after 2 accepts; out_data stable while stalled.
   - After release, all 4 words emerge in order, one per cycle.
6. Counter boundaries:
   - With CNT_W=2, 5 single-error words -> sec_count saturates at 2'b11.
   - cnt_clr asserted in the same cycle as a sec handshake -> sec_count=0.
   - rst_n=0 mid-stream -> out_valid=0 next cycle, counters 0.
